// File: rtl/riscv_pkg.sv
// Opcode and funct3 constants plus the memory-stage state type and decode helpers.
package riscv_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] fn3);
        if (is_store)
            return (fn3 == F3_SB) || (fn3 == F3_SH) || (fn3 == F3_SW);
        return (fn3 == F3_LB) || (fn3 == F3_LH) || (fn3 == F3_LW) ||
               (fn3 == F3_LBU) || (fn3 == F3_LHU);
    endfunction

    // Access size lives in fn3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] fn3, input logic [1:0] a);
        case (fn3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of ALU-side, data-memory and writeback signals around the memory stage.
interface mem_stage_if;
    logic        ALU_valid;
    logic [6:0]  ALU_opcode;
    logic [2:0]  ALU_fn_3;
    logic [4:0]  ALU_rd;
    logic [31:0] ALU_alu_val;
    logic [31:0] ALU_rs2_val;
    logic        MEM_stall;
    logic        MEM_fault;
    logic        DM_req;
    logic        DM_we;
    logic [31:0] DM_addr;
    logic [3:0]  DM_be;
    logic [31:0] DM_wdata;
    logic        DM_ack;
    logic [31:0] DM_rdata;
    logic        WB_valid;
    logic        WB_we;
    logic [4:0]  WB_rd;
    logic [31:0] WB_val;

    // Environment side: upstream stage plus data memory.
    modport master (
        output ALU_valid, ALU_opcode, ALU_fn_3, ALU_rd, ALU_alu_val, ALU_rs2_val,
        output DM_ack, DM_rdata,
        input  MEM_stall, MEM_fault, DM_req, DM_we, DM_addr, DM_be, DM_wdata,
        input  WB_valid, WB_we, WB_rd, WB_val
    );

    modport slave (
        input  ALU_valid, ALU_opcode, ALU_fn_3, ALU_rd, ALU_alu_val, ALU_rs2_val,
        input  DM_ack, DM_rdata,
        output MEM_stall, MEM_fault, DM_req, DM_we, DM_addr, DM_be, DM_wdata,
        output WB_valid, WB_we, WB_rd, WB_val
    );
endinterface

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_ext
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  fn3_i,
    output logic [31:0] val_o
);

    logic [31:0] lane;

    always_comb begin
        lane = rdata_i >> {addr_i, 3'b000};
        case (fn3_i)
            F3_LB:   val_o = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   val_o = {{16{lane[15]}}, lane[15:0]};
            F3_LBU:  val_o = {24'h0, lane[7:0]};
            F3_LHU:  val_o = {16'h0, lane[15:0]};
            default: val_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data port, load alignment and
// a registered writeback bundle; stalls upstream while a transaction is open.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input logic        clk,
    input logic        rst_n,
    mem_stage_if.slave bus
);

    // state | meaning
    // IDLE  | accepting ALU bundles; non-memory ops retire in one cycle
    // WAIT  | DM request outstanding; upstream stalled until ack or timeout

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        fn3_q, fn3_d;
    logic [4:0]        rd_q, rd_d;
    logic [1:0]        off_q, off_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_val_q, wb_val_d;
    logic              fault_q, fault_d;

    logic        is_load, is_store, is_alu, bad_access;
    logic [31:0] load_val;

    mem_load_ext u_ext (
        .rdata_i (bus.DM_rdata),
        .addr_i  (off_q),
        .fn3_i   (fn3_q),
        .val_o   (load_val)
    );

    assign is_load    = (bus.ALU_opcode == LOAD);
    assign is_store   = (bus.ALU_opcode == STORE);
    assign is_alu     = (bus.ALU_opcode == R_TYPE) || (bus.ALU_opcode == I_TYPE);
    assign bad_access = !f3_legal(is_store, bus.ALU_fn_3) ||
                        misaligned(bus.ALU_fn_3, bus.ALU_alu_val[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            fn3_q      <= '0;
            rd_q       <= '0;
            off_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            fn3_q      <= fn3_d;
            rd_q       <= rd_d;
            off_q      <= off_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_val_q   <= wb_val_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        fn3_d      = fn3_q;
        rd_d       = rd_q;
        off_d      = off_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_val_d   = wb_val_q;
        fault_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ALU_valid) begin
                    wb_rd_d = bus.ALU_rd;
                    if (is_load || is_store) begin
                        if (bad_access) begin
                            wb_valid_d = 1'b1;
                            wb_val_d   = '0;
                            fault_d    = 1'b1;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = '0;
                            req_d   = 1'b1;
                            we_d    = is_store;
                            addr_d  = {bus.ALU_alu_val[31:2], 2'b00};
                            fn3_d   = bus.ALU_fn_3;
                            rd_d    = bus.ALU_rd;
                            off_d   = bus.ALU_alu_val[1:0];
                            if (is_load) begin
                                be_d    = 4'b1111;
                                wdata_d = '0;
                            end else begin
                                case (bus.ALU_fn_3)
                                    F3_SB: begin
                                        be_d    = 4'b0001 << bus.ALU_alu_val[1:0];
                                        wdata_d = {4{bus.ALU_rs2_val[7:0]}};
                                    end
                                    F3_SH: begin
                                        be_d    = bus.ALU_alu_val[1] ? 4'b1100 : 4'b0011;
                                        wdata_d = {2{bus.ALU_rs2_val[15:0]}};
                                    end
                                    default: begin
                                        be_d    = 4'b1111;
                                        wdata_d = bus.ALU_rs2_val;
                                    end
                                endcase
                            end
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_val_d   = bus.ALU_alu_val;
                        wb_we_d    = is_alu && (bus.ALU_rd != 5'd0);
                    end
                end
            end
            WAIT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.DM_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (we_q) begin
                        wb_val_d = '0;
                    end else begin
                        wb_val_d = load_val;
                        wb_we_d  = (rd_q != 5'd0);
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_val_d   = '0;
                    fault_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.MEM_stall = (state_q == WAIT);
    assign bus.MEM_fault = fault_q;
    assign bus.DM_req    = req_q;
    assign bus.DM_we     = we_q;
    assign bus.DM_addr   = addr_q;
    assign bus.DM_be     = be_q;
    assign bus.DM_wdata  = wdata_q;
    assign bus.WB_valid  = wb_valid_q;
    assign bus.WB_we     = wb_we_q;
    assign bus.WB_rd     = wb_rd_q;
    assign bus.WB_val    = wb_val_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU. It consumes the ALU result as a load/store effective address, or passes it through as the result for R/I-type operations.
- Drives a single-outstanding req/ack data-memory port with byte enables, and aligns and sign- or zero-extends load data.
- Presents a registered writeback bundle.
- Stalls the upstream stage while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max WAIT cycles without DM_ack before abort (≥1).
- TO_W, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- ALU_valid, input, 1, upstream bundle valid.
- ALU_opcode, input, 7, instruction opcode.
- ALU_fn_3, input, 3, funct3.
- ALU_rd, input, 5, destination register.
- ALU_alu_val, input, 32, ALU result / effective address.
- ALU_rs2_val, input, 32, store data.
- MEM_stall, output, 1, upstream must hold ALU_* stable.
- MEM_fault, output, 1, one-cycle pulse: misaligned, illegal funct3, or timeout.
- DM_req, output, 1, memory request.
- DM_we, output, 1, 1 = store.
- DM_addr, output, 32, word-aligned address ({addr[31:2],2'b00}).
- DM_be, output, 4, byte enables.
- DM_wdata, output, 32, lane-replicated store data.
- DM_ack, input, 1, transaction complete; DM_rdata valid this cycle.
- DM_rdata, input, 32, read word.
- WB_valid, output, 1, writeback bundle valid (one cycle per accepted op).
- WB_we, output, 1, register write enable.
- WB_rd, output, 5, destination register.
- WB_val, output, 32, writeback value.

Behaviour:
- Reset (async, rst_n=0): state IDLE; timeout counter 0; all outputs 0. This includes DM_req, DM_we, DM_addr, DM_be, DM_wdata, MEM_stall, MEM_fault and all WB_* outputs.
- FSM states are IDLE and WAIT. MEM_stall = (state==WAIT), decoded combinationally from the state register.

IDLE, ALU_valid=0:
- WB_valid=0 next cycle.

IDLE, ALU_valid=1, opcode R_TYPE (0110011) or I_TYPE (0010011):
- Next edge registers WB_valid=1, WB_val=ALU_alu_val, WB_rd=ALU_rd, WB_we=(ALU_rd!=0).
- Latency 1.

IDLE, ALU_valid=1, other non-memory opcode:
- WB_valid=1, WB_we=0.

IDLE, ALU_valid=1, LOAD (0000011) or STORE (0100011):
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB, 001 SH, 010 SW.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Illegal or misaligned: no DM_req; MEM_fault=1 and WB_valid=1 with WB_we=0 for one cycle; stay in IDLE.
- Legal: next edge registers DM_req=1, DM_we, DM_addr, DM_be, DM_wdata; latches fn_3, rd and addr[1:0]; clears counter; state→WAIT.

Store lane formatting:
- SB: be = 4'b0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
- SW: be = 4'b1111; wdata = rs2.

Loads:
- DM_be = 4'b1111, DM_wdata = 0.

WAIT:
- DM_req and all DM_* outputs held stable; ALU_* ignored; counter increments each cycle.
- DM_ack=1 at edge: DM_req←0, state→IDLE, WB_valid←1.
  - Load: WB_val = extracted, extended data; WB_we = (rd!=0).
  - Store: WB_we = 0.
- Load extract: lane = DM_rdata >> (8*addr[1:0]). Byte = lane[7:0]; half = lane[15:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Minimum memory latency: 2 edges from accept to WB_valid (ack in the first WAIT cycle).
- Counter reaches TIMEOUT_CYCLES with no ack: DM_req←0, MEM_fault pulse, WB_valid=1 with WB_we=0, state→IDLE.
- DM_ack and timeout in the same cycle: ack wins.

Boundary cases:
- DM_ack while in IDLE: ignored.
- Reset mid-WAIT: DM_req drops immediately (async); the transaction is abandoned.
- The upstream stage may present the next op in the same cycle WAIT exits. It is accepted on the edge after MEM_stall falls.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants: R_TYPE, I_TYPE, LOAD, STORE.
  - Load/store funct3 codes: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW.
  - mem_state_t enum {IDLE, WAIT}.
- One combinational sub-module, mem_load_ext: inputs rdata, addr[1:0] and fn_3; output is the 32-bit extended value.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, DM_ack after 3 WAIT cycles -> DM_addr 0x100, DM_be 1111, DM_wdata 0xDEADBEEF; MEM_stall high exactly 3 cycles; WB_valid=1, WB_we=0.
- LB addr 0x203, DM_rdata 0x80FF1234, ack in first WAIT cycle -> WB_val 0xFFFFFF80, WB_valid two edges after accept. Same access as LBU -> WB_val 0x00000080.
- LH addr 0x202, DM_rdata 0x80010000 -> WB_val 0xFFFF8001. LH addr 0x201 -> MEM_fault pulse, DM_req never asserted, WB_we=0.
- SB addr 0x101, rs2 0x000000AB -> DM_be 0010, DM_wdata 0xABABABAB. SH addr 0x102, rs2 0x1234 -> DM_be 1100, DM_wdata 0x12341234.
- R-type, ALU_alu_val 0x5, rd=3 -> next cycle WB_valid=1, WB_we=1, WB_val 0x5. Same with rd=0 -> WB_we=0. Back-to-back ALU ops -> one WB per cycle, no stall.
- LW with DM_ack never asserted -> MEM_fault pulse after 255 WAIT cycles, return to IDLE. Separate run: rst_n low mid-WAIT -> DM_req, MEM_stall and WB_valid go to 0 immediately.
